// File: rtl/maj_serial_adder.sv
// -----------------------------------------------------------------------------
// maj_serial_adder
//
// Bit-serial adder built from one shared majority-gate full-adder cell. It
// processes one operand bit per clock, LSB first, and steps through three
// states:
//   IDLE -> accept operands
//   RUN  -> WIDTH cycles, one bit per cycle
//   DONE -> hold the result until the consumer takes it
//
// Parameters
//   WIDTH      operand/result width in bits (2..64), default 8
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand set presented
//   in_ready   block can accept operands (IDLE only)
//   a, b       operands (unsigned or two's complement)
//   cin        carry-in
//   sub        subtract select, sampled at accept (only with macro below)
//   out_valid  result held and valid (DONE)
//   out_ready  consumer accepts the result
//   sum        result, held until the next result is complete
//   cout       carry out of the MSB (for subtract: 1 = no borrow)
//   ovf        signed overflow: carry into MSB xor carry out of MSB
//
// Build option
//   MAJ_SERIAL_ADDER_SUB_EN  adds the sub port and a-b mode (~b, carry-in 1)
// -----------------------------------------------------------------------------
module maj_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef MAJ_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // r_a doubles as the result shift register: each RUN cycle shifts one
  // operand bit out of the LSB and the new sum bit into the MSB, so after
  // WIDTH cycles it holds the complete sum.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [WIDTH-1:0] w_b_in;
  logic             w_c_in;
  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic             w_co;
  logic             w_s;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

`ifdef MAJ_SERIAL_ADDER_SUB_EN
  // a - b = a + ~b + 1; cin is ignored in subtract mode.
  assign w_b_in = sub ? ~b : b;
  assign w_c_in = sub ? 1'b1 : cin;
`else
  assign w_b_in = b;
  assign w_c_in = cin;
`endif

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_run    = (r_state == S_RUN);
  assign w_last   = w_run && (r_cnt == LAST_BIT);

  // Shared full-adder cell in pure majority form:
  //   carry = MAJ(a, b, c)
  //   sum   = MAJ(~MAJ(a, b, c), c, MAJ(a, b, ~c))
  assign w_co = maj(r_a[0], r_b[0], r_c);
  assign w_s  = maj(~w_co, r_c, maj(r_a[0], r_b[0], ~r_c));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == LAST_BIT) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        // Return to IDLE only; in_ready is low here, so no accept can
        // coincide with the hand-off.
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= w_b_in;
      r_c   <= w_c_in;
      r_cnt <= '0;
    end else if (w_run) begin
      r_a   <= {w_s, r_a[WIDTH-1:1]};
      r_b   <= r_b >> 1;
      r_c   <= w_co;
      r_cnt <= r_cnt + 1'b1;
      // Visible outputs change only when a result completes, so the
      // previous result stays on sum/cout/ovf through IDLE and RUN.
      if (w_last) begin
        r_sum  <= {w_s, r_a[WIDTH-1:1]};
        r_cout <= w_co;
        r_ovf  <= r_c ^ w_co;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_maj_serial_adder.sv
module tb_maj_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       iv8, ir8, ov8, or8, cin8, co8, of8;
  logic [7:0] a8, b8, s8;
  logic       iv4, ir4, ov4, or4, cin4, co4, of4;
  logic [3:0] a4, b4, s4;
`ifdef MAJ_SERIAL_ADDER_SUB_EN
  logic       sub8;
  logic       sub4;
`endif

  maj_serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .cin(cin8),
`ifdef MAJ_SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8)
  );

  maj_serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .cin(cin4),
`ifdef MAJ_SERIAL_ADDER_SUB_EN
    .sub(sub4),
`endif
    .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .ovf(of4)
  );

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp8_t;

  typedef struct packed {
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
  } exp4_t;

  exp8_t q8[$];
  exp4_t q4[$];
  int errors = 0;
  int checks = 0;

  function automatic exp8_t model8(input logic [7:0] a, input logic [7:0] b,
                                   input logic c, input logic s);
    logic [7:0] bb;
    logic       cc;
    logic [8:0] r;
    exp8_t      e;
    bb = s ? ~b : b;
    cc = s ? 1'b1 : c;
    r  = {1'b0, a} + {1'b0, bb} + {8'd0, cc};
    e.sum  = r[7:0];
    e.cout = r[8];
    e.ovf  = (a[7] == bb[7]) && (r[7] != a[7]);
    return e;
  endfunction

  function automatic exp4_t model4(input logic [3:0] a, input logic [3:0] b,
                                   input logic c);
    logic [4:0] r;
    exp4_t      e;
    r = {1'b0, a} + {1'b0, b} + {4'd0, c};
    e.sum  = r[3:0];
    e.cout = r[4];
    e.ovf  = (a[3] == b[3]) && (r[3] != a[3]);
    return e;
  endfunction

  // One full WIDTH=8 transaction; entered and left 1 time unit after a rising edge.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic s, input int stall, input string name);
    int    n;
    exp8_t e;
    exp8_t got;
    n = 0;
    while (!ir8 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (ir8 !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_wait: in_ready=%b required 1", name, ir8);
    end
    a8 = a; b8 = b; cin8 = c; iv8 = 1'b1;
`ifdef MAJ_SERIAL_ADDER_SUB_EN
    sub8 = s;
`endif
    q8.push_back(model8(a, b, c, s));
    @(posedge clk); #1;
    // Inputs outside the accepting cycle must be ignored.
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
`ifdef MAJ_SERIAL_ADDER_SUB_EN
    sub8 = 1'($urandom);
`endif
    n = 0;
    while (!ov8 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles required 8", name, n);
    end
    got = {s8, co8, of8};
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({s8, co8, of8} !== got || ov8 !== 1'b1 || ir8 !== 1'b0) begin
        errors++;
        $display("FAIL %s stall%0d: sum/cout/ovf=%h/%b/%b ov=%b ir=%b required %h/%b/%b ov=1 ir=0",
                 name, k, s8, co8, of8, ov8, ir8, got.sum, got.cout, got.ovf);
      end
    end
    or8 = 1'b1;
    checks++;
    if (q8.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: queue empty, required one entry", name);
      e = '0;
    end else begin
      e = q8.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL %s result: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                 name, got.sum, got.cout, got.ovf, e.sum, e.cout, e.ovf);
      end
    end
    @(posedge clk); #1;
    or8 = 1'b0;
    checks++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1 || {s8, co8, of8} !== e) begin
      errors++;
      $display("FAIL %s release: ov=%b ir=%b sum=%h required ov=0 ir=1 sum=%h (held)",
               name, ov8, ir8, s8, e.sum);
    end
  endtask

  task automatic test_reset;
    int n;
    rst_n = 1'b0;
    iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
`ifdef MAJ_SERIAL_ADDER_SUB_EN
    sub8 = 1'b0; sub4 = 1'b0;
`endif
    #1;
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || s8 !== 8'h00 || co8 !== 1'b0 || of8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state8: ir=%b ov=%b sum=%h cout=%b ovf=%b required 1 0 00 0 0",
               ir8, ov8, s8, co8, of8);
    end
    checks++;
    if (ir4 !== 1'b1 || ov4 !== 1'b0 || s4 !== 4'h0) begin
      errors++;
      $display("FAIL reset_state4: ir=%b ov=%b sum=%h required 1 0 0", ir4, ov4, s4);
    end
    // Operands waiting while in reset are accepted on the first edge after release.
    a8 = 8'h03; b8 = 8'h04; iv8 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    checks++;
    if (ir8 !== 1'b0) begin
      errors++;
      $display("FAIL first_edge_accept: in_ready=%b required 0", ir8);
    end
    n = 0;
    while (!ov8 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (ov8 !== 1'b1 || s8 !== 8'h07 || co8 !== 1'b0 || n != 8) begin
      errors++;
      $display("FAIL first_result: ov=%b sum=%h cout=%b lat=%0d required 1 07 0 8",
               ov8, s8, co8, n);
    end
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
  endtask

  task automatic test_add_cases;
    op8(8'h7F, 8'h01, 1'b0, 1'b0, 0, "pos_ovf");
    checks++;
    if ({s8, co8, of8} !== {8'h80, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL pos_ovf_const: sum=%h cout=%b ovf=%b required 80 0 1", s8, co8, of8);
    end
    op8(8'hFF, 8'h01, 1'b0, 1'b0, 0, "carry_out");
    checks++;
    if ({s8, co8, of8} !== {8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL carry_out_const: sum=%h cout=%b ovf=%b required 00 1 0", s8, co8, of8);
    end
    op8(8'h00, 8'h00, 1'b1, 1'b0, 0, "cin_only");
    checks++;
    if ({s8, co8} !== {8'h01, 1'b0}) begin
      errors++;
      $display("FAIL cin_only_const: sum=%h cout=%b required 01 0", s8, co8);
    end
    op8(8'h80, 8'h80, 1'b0, 1'b0, 0, "neg_ovf");
    op8(8'hFF, 8'hFF, 1'b1, 1'b0, 0, "all_ones");
  endtask

  task automatic test_stall;
    op8(8'hA5, 8'h5A, 1'b1, 1'b0, 5, "stall5");
    op8(8'h3C, 8'h41, 1'b0, 1'b0, 2, "stall2");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 0, "b2b");
    end
  endtask

  task automatic test_abort;
    int seen;
    op8(8'h10, 8'h20, 1'b0, 1'b0, 0, "pre_abort");
    a8 = 8'h11; b8 = 8'h22; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1 || s8 !== 8'h00 || co8 !== 1'b0 || of8 !== 1'b0) begin
      errors++;
      $display("FAIL abort_async: ov=%b ir=%b sum=%h cout=%b ovf=%b required 0 1 00 0 0",
               ov8, ir8, s8, co8, of8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ov8 !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_result: out_valid high %0d cycles required 0", seen);
    end
  endtask

`ifdef MAJ_SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    op8(8'h05, 8'h07, 1'b0, 1'b1, 0, "sub_borrow");
    checks++;
    if ({s8, co8} !== {8'hFE, 1'b0}) begin
      errors++;
      $display("FAIL sub_borrow_const: sum=%h cout=%b required FE 0", s8, co8);
    end
    op8(8'h07, 8'h05, 1'b0, 1'b1, 0, "sub_noborrow");
    checks++;
    if ({s8, co8} !== {8'h02, 1'b1}) begin
      errors++;
      $display("FAIL sub_noborrow_const: sum=%h cout=%b required 02 1", s8, co8);
    end
    op8(8'h07, 8'h05, 1'b1, 1'b1, 0, "sub_cin_ignored");
    op8(8'h07, 8'h05, 1'b0, 1'b0, 0, "add_after_sub");
  endtask
`endif

  task automatic test_exhaustive4;
    int    n;
    int    st;
    exp4_t e;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          n = 0;
          while (!ir4 && n < 20) begin
            @(posedge clk); #1; n++;
          end
          a4 = 4'(ai); b4 = 4'(bi); cin4 = 1'(ci); iv4 = 1'b1;
          q4.push_back(model4(4'(ai), 4'(bi), 1'(ci)));
          @(posedge clk); #1;
          iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
          n = 0;
          while (!ov4 && n < 20) begin
            @(posedge clk); #1; n++;
          end
          checks++;
          if (n != 4) begin
            errors++;
            $display("FAIL w4_latency a=%h b=%h cin=%0d: got %0d required 4", ai, bi, ci, n);
          end
          st = $urandom_range(0, 2);
          repeat (st) begin
            @(posedge clk); #1;
          end
          or4 = 1'b1;
          checks++;
          if (q4.size() == 0) begin
            errors++;
            $display("FAIL w4_scoreboard: queue empty, required one entry");
          end else begin
            e = q4.pop_front();
            if ({s4, co4, of4} !== e || ov4 !== 1'b1) begin
              errors++;
              $display("FAIL w4_result a=%h b=%h cin=%0d: sum=%h cout=%b ovf=%b ov=%b required %h %b %b ov=1",
                       ai, bi, ci, s4, co4, of4, ov4, e.sum, e.cout, e.ovf);
            end
          end
          @(posedge clk); #1;
          or4 = 1'b0;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_cases();
    test_stall();
    test_back_to_back();
    test_abort();
`ifdef MAJ_SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_exhaustive4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/maj_serial_adder.md
MAJ_SERIAL_ADDER -- requirements
Module: maj_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operand set presented.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have ports a, b  input  WIDTH each  unsigned/two's-complement operands.
REQ-007 SHALL have port cin  input  1  carry-in.
REQ-008 SHALL have port out_valid  output  1  result held and valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port sum  output  WIDTH  result.
REQ-011 SHALL have port cout  output  1  carry out of MSB.
REQ-012 SHALL have port ovf  output  1  signed overflow flag.

Function
REQ-013 SHALL be a bit-serial adder: one operand bit per clock, LSB first, over three states IDLE, RUN, DONE.
REQ-014 SHALL compute each bit's carry as MAJ(a_i, b_i, c) and each sum bit as MAJ(~MAJ(a_i,b_i,c), c, MAJ(a_i,b_i,~c)), i.e. majority-gate form only; one majority-based full-adder cell shared across all bits.
REQ-015 IDLE: in_ready=1, out_valid=0; on in_valid&in_ready, SHALL capture a, b into shift registers, load carry register with cin, clear bit counter, go to RUN.
REQ-016 RUN: in_ready=0, out_valid=0; each cycle SHALL process bit i, shift result bit into sum register, update carry, increment counter; after bit WIDTH-1 go to DONE.
REQ-017 Latency SHALL be exactly WIDTH cycles: out_valid rises on the WIDTH-th rising edge after the accepting edge.
REQ-018 DONE: out_valid=1, in_ready=0; sum, cout, ovf SHALL stay stable while out_ready=0.
REQ-019 On out_valid&out_ready SHALL return to IDLE; new operands are not accepted in the same cycle (throughput one operation per WIDTH+2 cycles minimum).
REQ-020 cout SHALL equal carry out of bit WIDTH-1; ovf SHALL equal carry into bit WIDTH-1 XOR cout.
REQ-021 Changes on a, b, cin, in_valid outside the accepting cycle SHALL have no effect.
REQ-022 sum/cout/ovf SHALL hold the last result after leaving DONE until the next DONE entry.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, counter 0, carry 0, sum 0, cout 0, ovf 0, out_valid 0, in_ready 1, independent of clk.
REQ-024 Reset asserted in RUN or DONE SHALL abort the operation; no result is produced for it.
REQ-025 After rst_n deasserts, first accept SHALL be possible on the first rising edge.

Configuration
REQ-026 Macro MAJ_SERIAL_ADDER_SUB_EN SHALL gate a subtract mode.
REQ-027 With MAJ_SERIAL_ADDER_SUB_EN defined: extra port sub input 1, sampled at accept; sub=1 SHALL use ~b as operand and load carry with 1 (cin ignored), giving a-b; cout=1 means no borrow; sub=0 behaves as plain add.
REQ-028 Without MAJ_SERIAL_ADDER_SUB_EN: no sub port, add only, netlist free of subtract logic.

Verification
REQ-029 WIDTH=8, a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1, out_valid exactly 8 cycles after accept.
REQ-030 WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
REQ-031 out_ready held 0 for 5 cycles in DONE -> sum/cout/ovf unchanged, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-032 rst_n pulsed low after 3 RUN cycles -> out_valid=0, in_ready=1 immediately, no result ever emitted for that operation.
REQ-033 SUB_EN, WIDTH=8: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0; a=0x07, b=0x05 -> sum=0x02, cout=1.
REQ-034 WIDTH=4 exhaustive a, b, cin with random out_ready stalls -> every result matches a+b+cin reference model.
